instr_controller: RTL and testbench
===================================

Name: instr_controller

Overview:
Multi-cycle control FSM for the simple CPU. It consumes the fields produced by the instruction decoder (opcode, ALU_op) and drives the reg_sel input back into the decoder. It also sequences the datapath: register-file write, the A/B/C pipeline registers, status flags and the operand muxes. One instruction executes per start request; waiting indicates readiness for the next.

Parameters:
None.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request to execute the instruction currently held in IR; sampled only in WAIT
opcode  input  3  decoded ir[15:13]
ALU_op  input  2  decoded ir[12:11]
waiting  output  1  high only in WAIT state
illegal  output  1  high only in ILLEGAL state
reg_sel  output  2  to decoder: 00=Rm ir[2:0], 01=Rd ir[7:5], 10=Rn ir[10:8]; 11 never driven
wb_sel  output  2  write-back source: 00=C register, 10=sximm8; 01/11 reserved, never driven
w_en  output  1  register-file write enable
en_A  output  1  load A register
en_B  output  1  load B register
en_C  output  1  load C (ALU result) register
en_status  output  1  load Z/N/V status register
sel_A  output  1  1 = ALU A operand forced to 16'h0000, 0 = A register
sel_B  output  1  1 = sximm5, 0 = shifted B; always 0 for this ISA subset

Behaviour:
- Moore FSM; all outputs decode from the state register only. No output depends combinationally on inputs.
- States: WAIT, DECODE, WRITE_IMM, LOAD_A, LOAD_B, EXEC, EXEC_CMP, WRITE_RD, ILLEGAL.
- Reset: rst_n=0 at a clock edge forces WAIT, regardless of current state. This includes mid-instruction; any partial sequence is abandoned with no further w_en.
- Reset output values: waiting=1; all other outputs 0; reg_sel=00, wb_sel=00.
- Defaults in every state: all enables 0, sel_A=0, sel_B=0, reg_sel=00, wb_sel=00. Each state overrides only what is listed below.
- WAIT: waiting=1. start=1 -> DECODE; otherwise stay. start in any other state is ignored.
- DECODE: no enables. opcode/ALU_op are sampled here; IR must be stable from start until waiting returns. Dispatch:
  - opcode 110, ALU_op 10 (MOV Rn,#imm8) -> WRITE_IMM
  - opcode 110, ALU_op 00 (MOV Rd,Rm{,sh}) -> LOAD_B
  - opcode 101, ALU_op 00/10 (ADD, AND) -> LOAD_A
  - opcode 101, ALU_op 01 (CMP) -> LOAD_A
  - opcode 101, ALU_op 11 (MVN) -> LOAD_B
  - any other opcode/ALU_op combination -> ILLEGAL
- WRITE_IMM: reg_sel=10, wb_sel=10, w_en=1 -> WAIT.
- LOAD_A: reg_sel=10, en_A=1 -> LOAD_B.
- LOAD_B: reg_sel=00, en_B=1. Next state is EXEC_CMP if the instruction is CMP, else EXEC.
- EXEC: en_C=1. sel_A=1 if the instruction is MOV-register or MVN, else 0 -> WRITE_RD.
- EXEC_CMP: en_status=1, sel_A=0, en_C=0 -> WAIT.
- WRITE_RD: reg_sel=01, wb_sel=00, w_en=1 -> WAIT.
- ILLEGAL: illegal=1, no writes -> WAIT.
- Instruction class (MOV-register/MVN/CMP/other) is latched into an internal register at DECODE. Later states use the latched class, not the live opcode/ALU_op inputs.
- Busy cycles (waiting=0), counted from the edge that samples start:
  - MOV imm = 2
  - MOV reg = 4
  - MVN = 4
  - ADD = 5
  - AND = 5
  - CMP = 4
  - illegal = 2
- start held high continuously: a new instruction begins on the edge immediately after the cycle WAIT is re-entered, i.e. exactly one waiting=1 cycle between instructions.
- Exactly one w_en pulse per MOV/ADD/AND/MVN; zero for CMP and illegal. Exactly one en_status pulse per CMP.

Test Plan:
- Reset mid-ADD (drop rst_n in EXEC) -> next cycle WAIT, waiting=1, no w_en pulse ever appears for that ADD.
- opcode=110, ALU_op=10, start pulse -> DECODE, then WRITE_IMM with reg_sel=10, wb_sel=10, w_en=1, then waiting=1; 2 busy cycles.
- opcode=101, ALU_op=00 -> en_A with reg_sel=10, then en_B with reg_sel=00, then en_C with sel_A=0, then w_en with reg_sel=01, wb_sel=00; 5 busy cycles.
- opcode=101, ALU_op=01 (CMP) -> en_A, en_B, en_status=1; w_en and en_C never asserted; 4 busy cycles.
- opcode=110, ALU_op=00 and opcode=101, ALU_op=11 -> LOAD_A skipped, sel_A=1 during en_C, one w_en; 4 busy cycles each.
- opcode=111 (and 110/ALU_op=01) -> illegal=1 for exactly one cycle, no enables asserted. Separately, with start held high for three MOV imm instructions: waiting=1 exactly one cycle between each instruction. Also toggle opcode after DECODE: the sequence does not change.

Source files
------------

// File: rtl/instr_controller.sv
// instr_controller: multi-cycle Moore control FSM for the simple CPU.
// Sequences one instruction per start request. It drives the decoder's
// register select and the datapath enables and muxes.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start             - execute the instruction in IR (sampled in WAIT only)
//   opcode, ALU_op    - decoded ir[15:13], ir[12:11]
//   waiting, illegal  - FSM in WAIT / ILLEGAL
//   reg_sel           - decoder register select (00 Rm, 01 Rd, 10 Rn)
//   wb_sel            - write-back source (00 C, 10 sximm8)
//   w_en, en_A, en_B, en_C, en_status - datapath load enables
//   sel_A, sel_B      - ALU operand muxes
module instr_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  output logic       waiting,
  output logic       illegal,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B
);

  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_LOAD_A, S_LOAD_B,
    S_EXEC, S_EXEC_CMP, S_WRITE_RD, S_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {
    C_OTHER, C_MOVREG, C_MVN, C_CMP
  } iclass_t;

  state_t  state, next_state;
  iclass_t iclass, next_iclass;

  // Class is captured on the DECODE edge so later states ignore IR changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_WAIT;
      iclass <= C_OTHER;
    end else begin
      state  <= next_state;
      iclass <= next_iclass;
    end
  end

  always_comb begin
    next_state  = state;
    next_iclass = iclass;
    unique case (state)
      S_WAIT:      if (start) next_state = S_DECODE;
      S_DECODE: begin
        next_iclass = C_OTHER;
        next_state  = S_ILLEGAL;
        if (opcode == 3'b110) begin
          if (ALU_op == 2'b10) begin
            next_state = S_WRITE_IMM;
          end else if (ALU_op == 2'b00) begin
            next_state  = S_LOAD_B;
            next_iclass = C_MOVREG;
          end
        end else if (opcode == 3'b101) begin
          unique case (ALU_op)
            2'b00, 2'b10: next_state = S_LOAD_A;
            2'b01: begin
              next_state  = S_LOAD_A;
              next_iclass = C_CMP;
            end
            2'b11: begin
              next_state  = S_LOAD_B;
              next_iclass = C_MVN;
            end
            default: next_state = S_ILLEGAL;
          endcase
        end
      end
      S_WRITE_IMM: next_state = S_WAIT;
      S_LOAD_A:    next_state = S_LOAD_B;
      S_LOAD_B:    next_state = (iclass == C_CMP) ? S_EXEC_CMP : S_EXEC;
      S_EXEC:      next_state = S_WRITE_RD;
      S_EXEC_CMP:  next_state = S_WAIT;
      S_WRITE_RD:  next_state = S_WAIT;
      S_ILLEGAL:   next_state = S_WAIT;
      default:     next_state = S_WAIT;
    endcase
  end

  always_comb begin
    waiting   = 1'b0;
    illegal   = 1'b0;
    reg_sel   = 2'b00;
    wb_sel    = 2'b00;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    unique case (state)
      S_WAIT:      waiting = 1'b1;
      S_DECODE:    ;
      S_WRITE_IMM: begin
        reg_sel = 2'b10;
        wb_sel  = 2'b10;
        w_en    = 1'b1;
      end
      S_LOAD_A: begin
        reg_sel = 2'b10;
        en_A    = 1'b1;
      end
      S_LOAD_B:    en_B = 1'b1;
      S_EXEC: begin
        en_C  = 1'b1;
        sel_A = (iclass == C_MOVREG) || (iclass == C_MVN);
      end
      S_EXEC_CMP:  en_status = 1'b1;
      S_WRITE_RD: begin
        reg_sel = 2'b01;
        w_en    = 1'b1;
      end
      S_ILLEGAL:   illegal = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// Testbench for instr_controller: per-cycle expected output vectors are
// queued when an instruction is issued and popped/compared each cycle.
module tb_instr_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] alu_op;
  logic       waiting, illegal, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic [1:0] reg_sel, wb_sel;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [12:0] sbq[$];

  instr_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(alu_op),
    .waiting(waiting), .illegal(illegal), .reg_sel(reg_sel), .wb_sel(wb_sel),
    .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
    .sel_A(sel_A), .sel_B(sel_B)
  );

  always #5 clk = ~clk;

  // {waiting, illegal, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B}
  localparam logic [12:0] E_WAIT = {2'b10, 2'b00, 2'b00, 7'b0000000};
  localparam logic [12:0] E_DEC  = {2'b00, 2'b00, 2'b00, 7'b0000000};
  localparam logic [12:0] E_WIMM = {2'b00, 2'b10, 2'b10, 7'b1000000};
  localparam logic [12:0] E_LA   = {2'b00, 2'b10, 2'b00, 7'b0100000};
  localparam logic [12:0] E_LB   = {2'b00, 2'b00, 2'b00, 7'b0010000};
  localparam logic [12:0] E_EX0  = {2'b00, 2'b00, 2'b00, 7'b0001000};
  localparam logic [12:0] E_EX1  = {2'b00, 2'b00, 2'b00, 7'b0001010};
  localparam logic [12:0] E_CMP  = {2'b00, 2'b00, 2'b00, 7'b0000100};
  localparam logic [12:0] E_WRD  = {2'b00, 2'b01, 2'b00, 7'b1000000};
  localparam logic [12:0] E_ILL  = {2'b01, 2'b00, 2'b00, 7'b0000000};

  function automatic logic [12:0] obs();
    return {waiting, illegal, reg_sel, wb_sel, w_en, en_A, en_B, en_C,
            en_status, sel_A, sel_B};
  endfunction

  task automatic check_vec(input string tag, input logic [12:0] got,
                           input logic [12:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference dispatch: per-cycle outputs from DECODE through the WAIT cycle.
  task automatic push_instr(input logic [2:0] op, input logic [1:0] aop);
    sbq.push_back(E_DEC);
    if (op == 3'b110 && aop == 2'b10) sbq.push_back(E_WIMM);
    else if (op == 3'b110 && aop == 2'b00) begin
      sbq.push_back(E_LB); sbq.push_back(E_EX1); sbq.push_back(E_WRD);
    end else if (op == 3'b101 && (aop == 2'b00 || aop == 2'b10)) begin
      sbq.push_back(E_LA); sbq.push_back(E_LB); sbq.push_back(E_EX0);
      sbq.push_back(E_WRD);
    end else if (op == 3'b101 && aop == 2'b01) begin
      sbq.push_back(E_LA); sbq.push_back(E_LB); sbq.push_back(E_CMP);
    end else if (op == 3'b101 && aop == 2'b11) begin
      sbq.push_back(E_LB); sbq.push_back(E_EX1); sbq.push_back(E_WRD);
    end else sbq.push_back(E_ILL);
    sbq.push_back(E_WAIT);
  endtask

  // Called just after a negedge with the DUT in WAIT.
  task automatic run_one(input string tag, input logic [2:0] op,
                         input logic [1:0] aop, input bit toggle,
                         input int exp_busy, input int exp_wen,
                         input int exp_stat, input int exp_ill);
    int busy = 0, nw = 0, ns = 0, ni = 0, n = 0;
    logic [12:0] o;
    opcode = op; alu_op = aop; start = 1'b1;
    push_instr(op, aop);
    while (sbq.size() > 0) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (toggle && n == 2) begin opcode = ~op; alu_op = ~aop; end
      o = obs();
      check_vec(tag, o, sbq.pop_front());
      if (!waiting) busy++;
      if (w_en) nw++;
      if (en_status) ns++;
      if (illegal) ni++;
    end
    check_int({tag, "_busy"}, busy, exp_busy);
    check_int({tag, "_wen"}, nw, exp_wen);
    check_int({tag, "_status"}, ns, exp_stat);
    check_int({tag, "_illegal"}, ni, exp_ill);
    opcode = op; alu_op = aop;
  endtask

  initial begin
    int nw;
    rst_n = 1'b0; start = 1'b0; opcode = 3'b000; alu_op = 2'b00;
    @(negedge clk); @(negedge clk);
    check_vec("reset", obs(), E_WAIT);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("idle", obs(), E_WAIT);

    run_one("mov_imm", 3'b110, 2'b10, 1'b0, 2, 1, 0, 0);
    run_one("add",     3'b101, 2'b00, 1'b0, 5, 1, 0, 0);
    run_one("and",     3'b101, 2'b10, 1'b0, 5, 1, 0, 0);
    run_one("cmp",     3'b101, 2'b01, 1'b0, 4, 0, 1, 0);
    run_one("mov_reg", 3'b110, 2'b00, 1'b0, 4, 1, 0, 0);
    run_one("mvn",     3'b101, 2'b11, 1'b0, 4, 1, 0, 0);
    run_one("ill_111", 3'b111, 2'b00, 1'b0, 2, 0, 0, 1);
    run_one("ill_110", 3'b110, 2'b01, 1'b0, 2, 0, 0, 1);
    run_one("tog_add", 3'b101, 2'b00, 1'b1, 5, 1, 0, 0);
    run_one("tog_cmp", 3'b101, 2'b01, 1'b1, 4, 0, 1, 0);
    run_one("tog_mvn", 3'b101, 2'b11, 1'b1, 4, 1, 0, 0);

    // start held high across three MOV imm instructions.
    opcode = 3'b110; alu_op = 2'b10; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(E_DEC); sbq.push_back(E_WIMM); sbq.push_back(E_WAIT);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_vec("b2b", obs(), sbq.pop_front());
      if (k == 8) start = 1'b0;
    end
    @(negedge clk);
    check_vec("b2b_idle", obs(), E_WAIT);

    // Reset while in EXEC of an ADD: the write-back must never occur.
    opcode = 3'b101; alu_op = 2'b00; start = 1'b1;
    sbq.push_back(E_DEC); sbq.push_back(E_LA); sbq.push_back(E_LB);
    sbq.push_back(E_EX0);
    nw = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      check_vec("rst_add", obs(), sbq.pop_front());
      if (w_en) nw++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_vec("rst_mid", obs(), E_WAIT);
    if (w_en) nw++;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_vec("rst_after", obs(), E_WAIT);
      if (w_en) nw++;
    end
    check_int("rst_wen", nw, 0);

    run_one("post_rst", 3'b110, 2'b10, 1'b0, 2, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
